// File: rtl/elevator_controller_if.sv
// Button/emergency inputs and car position/direction/door outputs of the elevator controller.
interface elevator_controller_if;
  logic       Emergency;
  logic [3:0] floor_request;
  logic [3:0] current_floor;
  logic [1:0] direction;
  logic       door_status;

  modport master (
    output Emergency, floor_request,
    input  current_floor, direction, door_status
  );

  modport slave (
    input  Emergency, floor_request,
    output current_floor, direction, door_status
  );
endinterface

// File: rtl/elevator_controller.sv
// Single-car SCAN elevator controller: latches floor requests, moves the car, opens the door.
// Request acts on the next edge, one floor per MOVE_CYCLES edges; no backpressure (level inputs).
module elevator_controller #(
  parameter int NUM_FLOORS  = 16,
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_controller_if.slave bus
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERGENCY} state_t;

  state_t                state;
  logic [3:0]            cur_floor;
  logic [1:0]            dir_q;
  logic                  door_q;
  logic                  last_up;
  logic [NUM_FLOORS-1:0] pending;
  logic [MCW-1:0]        move_cnt;
  logic [DCW-1:0]        door_cnt;

  logic [NUM_FLOORS-1:0] req_oh, pend_eff, cur_oh, up_oh, dn_oh;
  logic                  above, below, at_cur, up_hit, dn_hit;
  logic                  req_here, move_last, door_last;

  // Decode helpers use loops rather than variable indexing so any NUM_FLOORS in 2..16 is safe.
  always_comb begin
    req_oh = '0;
    cur_oh = '0;
    up_oh  = '0;
    dn_oh  = '0;
    above  = 1'b0;
    below  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      req_oh[i] = (bus.floor_request == 4'(i));
      cur_oh[i] = (cur_floor == 4'(i));
      up_oh[i]  = (cur_floor + 4'd1 == 4'(i));
      dn_oh[i]  = (cur_floor - 4'd1 == 4'(i));
    end
    pend_eff = pending | req_oh;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (4'(i) > cur_floor) above = above | pend_eff[i];
      if (4'(i) < cur_floor) below = below | pend_eff[i];
    end
    at_cur    = |(pend_eff & cur_oh);
    up_hit    = |(pend_eff & up_oh);
    dn_hit    = |(pend_eff & dn_oh);
    req_here  = (bus.floor_request == cur_floor);
    move_last = (move_cnt == MCW'(MOVE_CYCLES - 1));
    door_last = (door_cnt == DCW'(DOOR_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir_q     <= 2'b00;
      door_q    <= 1'b0;
      last_up   <= 1'b1;
      pending   <= '0;
      move_cnt  <= '0;
      door_cnt  <= '0;
    end else if (bus.Emergency) begin
      state    <= EMERGENCY;
      dir_q    <= 2'b11;
      door_q   <= 1'b1;
      pending  <= '0;
      move_cnt <= '0;
      door_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          pending <= pend_eff;
          if (at_cur) begin
            pending  <= pend_eff & ~cur_oh;
            state    <= DOOR_OPEN;
            door_q   <= 1'b1;
            door_cnt <= '0;
          end else if (above) begin
            state    <= MOVE_UP;
            dir_q    <= 2'b01;
            last_up  <= 1'b1;
            move_cnt <= '0;
          end else if (below) begin
            state    <= MOVE_DOWN;
            dir_q    <= 2'b10;
            last_up  <= 1'b0;
            move_cnt <= '0;
          end
        end

        MOVE_UP: begin
          pending <= pend_eff;
          if (!move_last) begin
            move_cnt <= move_cnt + MCW'(1);
          end else begin
            move_cnt <= '0;
            if (!above) begin
              state <= IDLE;
              dir_q <= 2'b00;
            end else begin
              cur_floor <= cur_floor + 4'd1;
              if (up_hit) begin
                pending  <= pend_eff & ~up_oh;
                state    <= DOOR_OPEN;
                dir_q    <= 2'b00;
                door_q   <= 1'b1;
                door_cnt <= '0;
              end
            end
          end
        end

        MOVE_DOWN: begin
          pending <= pend_eff;
          if (!move_last) begin
            move_cnt <= move_cnt + MCW'(1);
          end else begin
            move_cnt <= '0;
            if (!below) begin
              state <= IDLE;
              dir_q <= 2'b00;
            end else begin
              cur_floor <= cur_floor - 4'd1;
              if (dn_hit) begin
                pending  <= pend_eff & ~dn_oh;
                state    <= DOOR_OPEN;
                dir_q    <= 2'b00;
                door_q   <= 1'b1;
                door_cnt <= '0;
              end
            end
          end
        end

        DOOR_OPEN: begin
          // A held button for this floor is never latched; it only keeps the door open.
          pending <= pend_eff & ~cur_oh;
          if (req_here) begin
            door_cnt <= '0;
          end else if (!door_last) begin
            door_cnt <= door_cnt + DCW'(1);
          end else begin
            door_q   <= 1'b0;
            door_cnt <= '0;
            move_cnt <= '0;
            if ((last_up && above) || (!last_up && !below && above)) begin
              state   <= MOVE_UP;
              dir_q   <= 2'b01;
              last_up <= 1'b1;
            end else if (below) begin
              state   <= MOVE_DOWN;
              dir_q   <= 2'b10;
              last_up <= 1'b0;
            end else begin
              state <= IDLE;
              dir_q <= 2'b00;
            end
          end
        end

        EMERGENCY: begin
          state   <= IDLE;
          dir_q   <= 2'b00;
          door_q  <= 1'b0;
          pending <= '0;
        end

        default: begin
          state  <= IDLE;
          dir_q  <= 2'b00;
          door_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.current_floor = cur_floor;
  assign bus.direction     = dir_q;
  assign bus.door_status   = door_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller (MOVE_CYCLES=2, DOOR_CYCLES=3, 16 floors).
module tb_elevator_controller;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  elevator_controller_if bus();

  elevator_controller #(
    .NUM_FLOORS (16),
    .MOVE_CYCLES(2),
    .DOOR_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int fl, input int dir, input int door);
    check({tag, ".floor"}, 32'(bus.current_floor), 32'(fl));
    check({tag, ".dir"},   32'(bus.direction),     32'(dir));
    check({tag, ".door"},  32'(bus.door_status),   32'(door));
  endtask

  // Leaves reset deasserted with req applied, so the next tick is edge 0.
  task automatic do_reset(input logic [3:0] req);
    reset             = 1'b1;
    bus.Emergency     = 1'b0;
    tick();
    tick();
    reset             = 1'b0;
    bus.floor_request = req;
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    reset             = 1'b1;
    bus.Emergency     = 1'b0;
    bus.floor_request = 4'd0;

    // 1: reset state
    tick();
    tick();
    expect_out("reset", 0, 0, 0);

    // 2: go to 5, serve, then head down to held request 0
    reset             = 1'b0;
    bus.floor_request = 4'd5;
    tick();
    expect_out("t2.e0", 0, 1, 0);
    bus.floor_request = 4'd0;
    for (int e = 1; e < 10; e++) begin
      tick();
      check("t2.climb_floor", 32'(bus.current_floor), 32'(e / 2));
      check("t2.climb_dir",   32'(bus.direction),     32'd1);
    end
    tick();
    expect_out("t2.e10", 5, 0, 1);
    tick();
    tick();
    check("t2.e12_door", 32'(bus.door_status), 32'd1);
    tick();
    expect_out("t2.e13", 5, 2, 0);
    for (int e = 14; e <= 23; e++) tick();
    expect_out("t2.e23", 0, 0, 1);

    // 3: request behind the car is served after reversing
    do_reset(4'd7);
    tick();
    check("t3.e0_dir", 32'(bus.direction), 32'd1);
    bus.floor_request = 4'd0;
    for (int e = 1; e <= 8; e++) tick();
    check("t3.e8_floor", 32'(bus.current_floor), 32'd4);
    bus.floor_request = 4'd2;
    tick();
    bus.floor_request = 4'd0;
    for (int e = 10; e <= 13; e++) tick();
    check("t3.e13_dir", 32'(bus.direction), 32'd1);
    tick();
    expect_out("t3.e14", 7, 0, 1);
    for (int e = 15; e <= 17; e++) tick();
    expect_out("t3.e17", 7, 2, 0);
    for (int e = 18; e <= 25; e++) tick();
    expect_out("t3.e25", 3, 2, 0);
    tick();
    tick();
    expect_out("t3.e27", 2, 0, 1);

    // 4: emergency between floors 4 and 5
    do_reset(4'd7);
    for (int e = 0; e <= 8; e++) tick();
    check("t4.e8_floor", 32'(bus.current_floor), 32'd4);
    bus.Emergency = 1'b1;
    tick();
    expect_out("t4.emg", 4, 3, 1);
    tick();
    tick();
    expect_out("t4.emg_hold", 4, 3, 1);
    bus.Emergency     = 1'b0;
    bus.floor_request = 4'd4;
    tick();
    expect_out("t4.release", 4, 0, 0);
    tick();
    expect_out("t4.door", 4, 0, 1);
    bus.floor_request = 4'd3;
    tick();
    tick();
    check("t4.door_hold", 32'(bus.door_status), 32'd1);
    tick();
    // floor 7 was discarded, so only the new request below is left
    expect_out("t4.after", 4, 2, 0);

    // 5: held button at the current floor keeps the door open
    do_reset(4'd3);
    for (int e = 0; e <= 6; e++) tick();
    expect_out("t5.arrive", 3, 0, 1);
    bus.Emergency = 1'b1;
    tick();
    check("t5.emg_dir", 32'(bus.direction), 32'd3);
    bus.Emergency = 1'b0;
    tick();
    expect_out("t5.idle", 3, 0, 0);
    tick();
    expect_out("t5.open", 3, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t5.held_door", 32'(bus.door_status), 32'd1);
    end
    bus.floor_request = 4'd0;
    tick();
    tick();
    check("t5.rel2_door", 32'(bus.door_status), 32'd1);
    tick();
    expect_out("t5.closed", 3, 2, 0);

    // 6: reset mid-move, then run to the top floor
    do_reset(4'd9);
    for (int e = 0; e <= 5; e++) tick();
    expect_out("t6.mid", 2, 1, 0);
    reset             = 1'b1;
    bus.floor_request = 4'd15;
    tick();
    expect_out("t6.reset", 0, 0, 0);
    reset = 1'b0;
    tick();
    check("t6.e0_dir", 32'(bus.direction), 32'd1);
    for (int e = 1; e <= 18; e++) tick();
    expect_out("t6.pass9", 9, 1, 0);
    for (int e = 19; e <= 30; e++) tick();
    expect_out("t6.top", 15, 0, 1);
    for (int k = 0; k < 8; k++) tick();
    expect_out("t6.stay", 15, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
